// File: rtl/xadc_drp_responder.sv
// xadc_drp_responder: cycle-level stand-in for the XADC wizard DRP port.
// A free-running conversion timer loads sample_i into the VAUX6 status
// register and pulses eoc/eos, while a small DRP FSM answers reads and
// writes after a fixed latency.
// Optional feature macro: XADC_RESP_AVERAGE_EN (4-sample moving average on
// the converted value; when undefined the raw sample is stored).
module xadc_drp_responder #(
  parameter int         CONV_PERIOD = 26,
  parameter int         DRP_LATENCY = 4,
  parameter logic [6:0] AUX_ADDR    = 7'h16
) (
  input  logic        clk_78MHz_i,
  input  logic        reset_i,
  input  logic [11:0] sample_i,
  input  logic        den_i,
  input  logic        dwe_i,
  input  logic [6:0]  daddr_i,
  input  logic [15:0] di_i,
  output logic [15:0] do_o,
  output logic        drdy_o,
  output logic        eoc_o,
  output logic        eos_o,
  output logic        busy_o,
  output logic [4:0]  channel_o,
  output logic        err_o
);

  localparam int                CNT_W         = (CONV_PERIOD > 1) ? $clog2(CONV_PERIOD) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST      = CNT_W'(CONV_PERIOD - 1);
  localparam logic [3:0]        LAT_INIT      = 4'(DRP_LATENCY - 1);
  localparam logic [4:0]        VAUX6_CHANNEL = 5'd22;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Conversion timer state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             eoc_q;
  logic             alive_q;
  logic             loadSample;
  logic [11:0]      newSample;
  logic [15:0]      aux_q;

  // DRP transaction state
  logic [1:0]  state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic        reqWe_q, reqWe_d;
  logic [6:0]  reqAddr_q, reqAddr_d;
  logic [15:0] reqDi_q, reqDi_d;
  logic        err_q, err_d;
  logic [15:0] do_q;
  logic [15:0] cfgMem_q [64];
  logic        respEnter;
  logic [15:0] readData;

  assign loadSample = (cnt_q == CNT_LAST);
  assign cnt_d      = loadSample ? '0 : cnt_q + CNT_W'(1);

  // Free-running conversion counter; eoc is registered so it lands on cnt==0
  always_ff @(posedge clk_78MHz_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q   <= '0;
      eoc_q   <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      eoc_q   <= loadSample;
      alive_q <= 1'b1;
    end
  end

`ifdef XADC_RESP_AVERAGE_EN
  logic [11:0] hist0_q, hist1_q, hist2_q;
  logic [13:0] avgSum;

  assign avgSum    = 14'(sample_i) + 14'(hist0_q) + 14'(hist1_q) + 14'(hist2_q);
  assign newSample = 12'(avgSum >> 2);

  // Keep the three previous samples so the stored value is a 4-tap average
  always_ff @(posedge clk_78MHz_i or negedge reset_i) begin
    if (!reset_i) begin
      hist0_q <= '0;
      hist1_q <= '0;
      hist2_q <= '0;
    end else if (loadSample) begin
      hist0_q <= sample_i;
      hist1_q <= hist0_q;
      hist2_q <= hist1_q;
    end
  end
`else
  assign newSample = sample_i;
`endif

  // Status register for VAUX6, left-justified so that do/16 equals the sample
  always_ff @(posedge clk_78MHz_i or negedge reset_i) begin
    if (!reset_i) begin
      aux_q <= '0;
    end else if (loadSample) begin
      aux_q <= {newSample, 4'h0};
    end
  end

  // DRP FSM next state: latch the request in IDLE, count down in WAIT,
  // flag any strobe that arrives while a transaction is still pending
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    reqWe_d   = reqWe_q;
    reqAddr_d = reqAddr_q;
    reqDi_d   = reqDi_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (den_i) begin
          reqWe_d   = dwe_i;
          reqAddr_d = daddr_i;
          reqDi_d   = di_i;
          if (DRP_LATENCY <= 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            lat_d   = LAT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (den_i) begin
          err_d = 1'b1;
        end
        if (lat_q <= 4'd1) begin
          state_d = ST_RESP;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (den_i) begin
          err_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // RESP always returns to IDLE, so a next state of RESP marks the entry edge;
  // using the _d request fields covers the zero-wait latency-1 case
  assign respEnter = (state_d == ST_RESP);

  // Read mux: config RAM in the upper half, only the VAUX6 status is non-zero below
  always_comb begin
    readData = 16'h0000;
    if (reqAddr_d[6]) begin
      readData = cfgMem_q[reqAddr_d[5:0]];
    end else if (reqAddr_d == AUX_ADDR) begin
      readData = aux_q;
    end
  end

  // DRP FSM registers; reset mid-transaction simply drops the request
  always_ff @(posedge clk_78MHz_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= ST_IDLE;
      lat_q     <= '0;
      reqWe_q   <= 1'b0;
      reqAddr_q <= '0;
      reqDi_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      reqWe_q   <= reqWe_d;
      reqAddr_q <= reqAddr_d;
      reqDi_q   <= reqDi_d;
      err_q     <= err_d;
    end
  end

  // Read data is captured on the edge entering RESP, before any same-edge sample load
  always_ff @(posedge clk_78MHz_i or negedge reset_i) begin
    if (!reset_i) begin
      do_q <= '0;
    end else if (respEnter && !reqWe_d) begin
      do_q <= readData;
    end
  end

  // Config RAM writes commit with the response; status-space writes are dropped
  always_ff @(posedge clk_78MHz_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < 64; i++) begin
        cfgMem_q[i] <= '0;
      end
    end else if (respEnter && reqWe_d && reqAddr_d[6]) begin
      cfgMem_q[reqAddr_d[5:0]] <= reqDi_d;
    end
  end

  assign do_o      = do_q;
  assign drdy_o    = (state_q == ST_RESP);
  assign eoc_o     = eoc_q;
  assign eos_o     = eoc_q;
  assign busy_o    = (cnt_q != '0);
  assign channel_o = alive_q ? VAUX6_CHANNEL : 5'd0;
  assign err_o     = err_q;

endmodule

// File: tb/tb_xadc_drp_responder.sv
// tb_xadc_drp_responder: scoreboard bench for the XADC DRP responder.
// Expected read data is queued when a request is driven and compared when
// drdy_o appears. Honours XADC_RESP_AVERAGE_EN for the averaging scenario.
module tb_xadc_drp_responder;

  localparam int         P   = 26;
  localparam int         L   = 4;
  localparam logic [6:0] AUX = 7'h16;

  logic        clk = 1'b0;
  logic        rstN;
  logic [11:0] sample;
  logic        denDrv;
  logic        tieDen;
  logic        denIn;
  logic        dwe;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic [15:0] dout;
  logic        drdy;
  logic        eoc;
  logic        eos;
  logic        busy;
  logic [4:0]  channel;
  logic        err;

  int checks = 0;
  int fails  = 0;
  int k;

  logic [15:0] expQ [$];
  logic [15:0] cfgModel [64];
  logic [15:0] auxModel;
  logic [15:0] lastDo;

  assign denIn = tieDen ? eoc : denDrv;

  xadc_drp_responder #(
    .CONV_PERIOD (P),
    .DRP_LATENCY (L),
    .AUX_ADDR    (AUX)
  ) dut (
    .clk_78MHz_i (clk),
    .reset_i     (rstN),
    .sample_i    (sample),
    .den_i       (denIn),
    .dwe_i       (dwe),
    .daddr_i     (daddr),
    .di_i        (di),
    .do_o        (dout),
    .drdy_o      (drdy),
    .eoc_o       (eoc),
    .eos_o       (eos),
    .busy_o      (busy),
    .channel_o   (channel),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // Rising edges since the last reset release
  always @(posedge clk or negedge rstN) begin
    if (!rstN) k <= 0;
    else       k <= k + 1;
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void modelReset();
    for (int i = 0; i < 64; i++) cfgModel[i] = 16'h0000;
    auxModel = 16'h0000;
    lastDo   = 16'h0000;
    expQ.delete();
  endfunction

  // Reference DRP behaviour: returns the do_o value expected with drdy_o
  function automatic logic [15:0] modelAccess(input bit we, input logic [6:0] a, input logic [15:0] d);
    logic [15:0] r;
    if (we) begin
      if (a[6]) cfgModel[a[5:0]] = d;
      return lastDo;
    end
    if (a[6])          r = cfgModel[a[5:0]];
    else if (a == AUX) r = auxModel;
    else               r = 16'h0000;
    lastDo = r;
    return r;
  endfunction

  function automatic logic [15:0] popExp();
    if (expQ.size() > 0) return expQ.pop_front();
    return 16'hDEAD;
  endfunction

  // Single-cycle DRP strobe, called at a falling edge
  task automatic applyStimulus(input bit we, input logic [6:0] a, input logic [15:0] d);
    denDrv = 1'b1;
    dwe    = we;
    daddr  = a;
    di     = d;
    @(negedge clk);
    denDrv = 1'b0;
    dwe    = 1'b0;
  endtask

  task automatic waitDrdy(input int limit, output bit seen, output int cycles);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (drdy === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic waitEoc(input int limit, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < limit && !seen; c++) begin
      @(negedge clk);
      if (eoc === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    rstN   = 1'b0;
    denDrv = 1'b0;
    tieDen = 1'b0;
    repeat (cycles) @(negedge clk);
    modelReset();
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    logic [2:0] expTimer;
    int         eocCount;
    denDrv = 1'b0; tieDen = 1'b0; dwe = 1'b0; daddr = '0; di = '0;
    sample = 12'h123;
    rstN   = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({dout, drdy, eoc, eos, busy, channel, err} !== 26'h0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: actual=%h required=0", {dout, drdy, eoc, eos, busy, channel, err});
    end
    modelReset();
    rstN = 1'b1;
    eocCount = 0;
    for (int j = 1; j <= 80; j++) begin
      @(negedge clk);
      expTimer = {(j % P == 0), (j % P == 0), (j % P != 0)};
      checks++;
      if ({eoc, eos, busy} !== expTimer) begin
        fails++;
        $display("[TB] FAIL timer_cycle%0d: actual eoc/eos/busy=%b required=%b", j, {eoc, eos, busy}, expTimer);
      end
      checks++;
      if ({drdy, err, dout} !== 18'h0) begin
        fails++;
        $display("[TB] FAIL idle_drp_cycle%0d: actual=%h required=0", j, {drdy, err, dout});
      end
      if (eoc === 1'b1) eocCount++;
    end
    checks++;
    if (channel !== 5'd22) begin
      fails++;
      $display("[TB] FAIL channel: actual=%0d required=22", channel);
    end
    checks++;
    if (eocCount != 3) begin
      fails++;
      $display("[TB] FAIL eoc_count: actual=%0d required=3", eocCount);
    end
  endtask

  task automatic test_sample_readback();
    bit          seen;
    int          cyc;
    logic [15:0] e;
    sample = 12'hABC;
    daddr  = AUX;
    dwe    = 1'b0;
    tieDen = 1'b1;
    for (int i = 0; i < 2; i++) begin
      waitEoc(60, seen);
      checks++;
      if (!seen) begin
        fails++;
        $display("[TB] FAIL readback_eoc%0d: actual=no eoc required=eoc", i);
      end
      auxModel = 16'hABC0;
      expQ.push_back(modelAccess(1'b0, AUX, 16'h0));
      waitDrdy(10, seen, cyc);
      checks++;
      if (!seen || cyc != L) begin
        fails++;
        $display("[TB] FAIL readback_latency%0d: actual seen=%0d cycles=%0d required cycles=%0d", i, seen, cyc, L);
      end
      e = popExp();
      checks++;
      if (dout !== e) begin
        fails++;
        $display("[TB] FAIL readback_data%0d: actual=%h required=%h", i, dout, e);
      end
      checks++;
      if (dout[15:4] !== 12'hABC) begin
        fails++;
        $display("[TB] FAIL readback_div16_%0d: actual=%h required=abc", i, dout[15:4]);
      end
      @(negedge clk);
      checks++;
      if (drdy !== 1'b0) begin
        fails++;
        $display("[TB] FAIL readback_drdy_pulse%0d: actual=%b required=0", i, drdy);
      end
    end
    tieDen = 1'b0;
  endtask

  task automatic test_config_rw();
    bit          weT   [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [6:0]  addrT [9] = '{7'h41, 7'h41, 7'h10, 7'h10, 7'h7F, 7'h7F, 7'h40, 7'h16, 7'h15};
    logic [15:0] dataT [9] = '{16'h1234, 16'h0, 16'hFFFF, 16'h0, 16'hBEEF, 16'h0, 16'h0, 16'h0, 16'h0};
    bit          seen;
    int          cyc;
    logic [15:0] e;
    @(negedge clk);
    for (int s = 0; s < 9; s++) begin
      expQ.push_back(modelAccess(weT[s], addrT[s], dataT[s]));
      applyStimulus(weT[s], addrT[s], dataT[s]);
      waitDrdy(10, seen, cyc);
      checks++;
      if (!seen || cyc != L - 1) begin
        fails++;
        $display("[TB] FAIL cfg_latency_step%0d: actual seen=%0d cycles=%0d required cycles=%0d", s, seen, cyc, L - 1);
      end
      e = popExp();
      checks++;
      if (dout !== e) begin
        fails++;
        $display("[TB] FAIL cfg_data_step%0d addr=%h we=%0d: actual=%h required=%h", s, addrT[s], weT[s], dout, e);
      end
      @(negedge clk);
      checks++;
      if ({err, drdy} !== 2'b00) begin
        fails++;
        $display("[TB] FAIL cfg_after_step%0d: actual err/drdy=%b required=00", s, {err, drdy});
      end
    end
  endtask

  task automatic test_collision();
    bit          seen;
    int          cyc;
    int          drdyCount;
    logic [15:0] e;
    expQ.push_back(modelAccess(1'b0, 7'h41, 16'h0));
    denDrv = 1'b1; dwe = 1'b0; daddr = 7'h41;
    @(negedge clk);
    denDrv = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL collision_err_early: actual=%b required=0", err);
    end
    @(negedge clk);
    denDrv = 1'b1; dwe = 1'b1; daddr = 7'h7F; di = 16'h0000;
    @(negedge clk);
    denDrv = 1'b0; dwe = 1'b0;
    checks++;
    if ({err, drdy} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL collision_err_set: actual err/drdy=%b required=10", {err, drdy});
    end
    @(negedge clk);
    checks++;
    if (drdy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL collision_drdy: actual=%b required=1", drdy);
    end
    e = popExp();
    checks++;
    if (dout !== e) begin
      fails++;
      $display("[TB] FAIL collision_data: actual=%h required=%h", dout, e);
    end
    drdyCount = 0;
    repeat (8) begin
      @(negedge clk);
      if (drdy === 1'b1) drdyCount++;
    end
    checks++;
    if (drdyCount != 0 || err !== 1'b1) begin
      fails++;
      $display("[TB] FAIL collision_extra: actual extra drdy=%0d err=%b required 0 and 1", drdyCount, err);
    end
    expQ.push_back(modelAccess(1'b0, 7'h7F, 16'h0));
    applyStimulus(1'b0, 7'h7F, 16'h0);
    waitDrdy(10, seen, cyc);
    e = popExp();
    checks++;
    if (!seen || dout !== e) begin
      fails++;
      $display("[TB] FAIL collision_no_clobber: actual seen=%0d data=%h required=%h", seen, dout, e);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    bit          weT   [3] = '{1'b0, 1'b1, 1'b0};
    logic [6:0]  addrT [3] = '{7'h41, 7'h50, 7'h50};
    logic [15:0] dataT [3] = '{16'h0, 16'h5A5A, 16'h0};
    bit          seen;
    int          cyc;
    int          drdyCount;
    logic [15:0] e;
    applyStimulus(1'b0, 7'h41, 16'h0);
    @(negedge clk);
    rstN = 1'b0;
    drdyCount = 0;
    repeat (3) begin
      @(negedge clk);
      if (drdy === 1'b1) drdyCount++;
    end
    checks++;
    if ({dout, err} !== 17'h0) begin
      fails++;
      $display("[TB] FAIL abort_state: actual do/err=%h required=0", {dout, err});
    end
    modelReset();
    rstN = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (drdy === 1'b1) drdyCount++;
    end
    checks++;
    if (drdyCount != 0) begin
      fails++;
      $display("[TB] FAIL abort_no_drdy: actual=%0d required=0", drdyCount);
    end
    for (int s = 0; s < 3; s++) begin
      expQ.push_back(modelAccess(weT[s], addrT[s], dataT[s]));
      applyStimulus(weT[s], addrT[s], dataT[s]);
      waitDrdy(10, seen, cyc);
      e = popExp();
      checks++;
      if (!seen || cyc != L - 1 || dout !== e) begin
        fails++;
        $display("[TB] FAIL abort_fresh_step%0d: actual seen=%0d cycles=%0d data=%h required data=%h", s, seen, cyc, dout, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_average();
    logic [11:0] vals [4] = '{12'd100, 12'd200, 12'd300, 12'd400};
`ifdef XADC_RESP_AVERAGE_EN
    logic [11:0] expv [4] = '{12'd25, 12'd75, 12'd150, 12'd250};
    logic [11:0] expNext  = 12'd350;
`else
    logic [11:0] expv [4] = '{12'd100, 12'd200, 12'd300, 12'd400};
    logic [11:0] expNext  = 12'd500;
`endif
    bit          seen;
    int          cyc;
    int          target;
    int          guard;
    logic [15:0] e;
    sample = vals[0];
    doReset(3);
    for (int i = 0; i < 4; i++) begin
      sample = vals[i];
      waitEoc(40, seen);
      checks++;
      if (!seen) begin
        fails++;
        $display("[TB] FAIL avg_eoc%0d: actual=no eoc required=eoc", i);
      end
      auxModel = {expv[i], 4'h0};
      expQ.push_back(modelAccess(1'b0, AUX, 16'h0));
      applyStimulus(1'b0, AUX, 16'h0);
      waitDrdy(10, seen, cyc);
      e = popExp();
      checks++;
      if (!seen || dout !== e) begin
        fails++;
        $display("[TB] FAIL avg_read%0d: actual seen=%0d data=%h required=%h", i, seen, dout, e);
      end
      checks++;
      if (dout[15:4] !== expv[i]) begin
        fails++;
        $display("[TB] FAIL avg_value%0d: actual=%0d required=%0d", i, dout[15:4], expv[i]);
      end
      @(negedge clk);
    end
    sample = 12'd500;
    target = ((k / P) + 1) * P - 4;
    guard  = 0;
    while (k < target && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    expQ.push_back(modelAccess(1'b0, AUX, 16'h0));
    applyStimulus(1'b0, AUX, 16'h0);
    waitDrdy(10, seen, cyc);
    checks++;
    if (!seen || cyc != L - 1 || eoc !== 1'b1) begin
      fails++;
      $display("[TB] FAIL same_edge_timing: actual seen=%0d cycles=%0d eoc=%b required cycles=%0d eoc=1", seen, cyc, eoc, L - 1);
    end
    e = popExp();
    checks++;
    if (dout !== e) begin
      fails++;
      $display("[TB] FAIL same_edge_data: actual=%h required=%h", dout, e);
    end
    @(negedge clk);
    auxModel = {expNext, 4'h0};
    expQ.push_back(modelAccess(1'b0, AUX, 16'h0));
    applyStimulus(1'b0, AUX, 16'h0);
    waitDrdy(10, seen, cyc);
    e = popExp();
    checks++;
    if (!seen || dout !== e) begin
      fails++;
      $display("[TB] FAIL after_same_edge_data: actual seen=%0d data=%h required=%h", seen, dout, e);
    end
    @(negedge clk);
  endtask

  initial begin
    rstN   = 1'b0;
    denDrv = 1'b0;
    tieDen = 1'b0;
    dwe    = 1'b0;
    daddr  = '0;
    di     = '0;
    sample = '0;
    test_reset();
    test_sample_readback();
    test_config_rw();
    test_collision();
    test_abort();
    test_average();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
